// File: rtl/packet_distributor_pkg.sv
// Shared constants for the aggregator / distributor pair: engine ids, FSM state codes, row shift.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package packet_distributor_pkg;

    // Engine id carried by next_engine; the aggregator uses the same encoding.
    typedef enum logic {
        ENGINE1 = 1'b0,
        ENGINE2 = 1'b1
    } engine_e;

    // HEADER: the next accepted beat is a packet header. BODY: mid-packet.
    typedef enum logic {
        HEADER = 1'b0,
        BODY   = 1'b1
    } state_e;

    // LENGTH is in units of 8; (LENGTH >> ROW_SHIFT) is the number of body beats.
    localparam int ROW_SHIFT = 3;

    function automatic engine_e other_engine(input engine_e e);
        return (e == ENGINE1) ? ENGINE2 : ENGINE1;
    endfunction

endpackage

// File: rtl/packet_distributor_engine_out_stage.sv
// Purpose: 1-deep valid/data output register towards one engine.
// Latency: 1 cycle from load to out_vld/out_dat.
// Backpressure: load_rdy = !out_vld || out_rdy; out_dat holds while out_vld && !out_rdy.
// Ports: clk/reset, load_vld/load_dat (from the distributor), load_rdy (to the distributor),
//        out_dat/out_vld/out_rdy (engine handshake).
module engine_out_stage #(
    parameter int DATA_WIDTH = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_vld,
    input  logic [DATA_WIDTH:0] load_dat,
    output logic                load_rdy,
    output logic [DATA_WIDTH:0] out_dat,
    output logic                out_vld,
    input  logic                out_rdy
);

    logic                valid_q, valid_d;
    logic [DATA_WIDTH:0] data_q,  data_d;

    assign load_rdy = !valid_q || out_rdy;
    assign out_vld  = valid_q;
    assign out_dat  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        // A load while the old beat drains replaces it in place, so no bubble appears.
        if (load_vld && load_rdy) begin
            valid_d = 1'b1;
            data_d  = load_dat;
        end else if (valid_q && out_rdy) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/packet_distributor.sv
// Purpose: split one aggregated packet stream back to ENGINE1/ENGINE2, whole packets alternating.
// Latency: 1 cycle DATA_IN -> DATA_OUTx; 1 beat/cycle without backpressure.
// Backpressure: ready follows the output stage of the currently selected engine; the other stage drains freely.
// Ports: DATA_IN/valid_in/ready (aggregated input), DATA_OUTx/valid_x/ready_x (per engine), busy (mid-packet).
// Optional: define DISTRIB_PKT_CNT_EN to add pkt_cnt_1/pkt_cnt_2, per-engine completed-packet counters.
module packet_distributor
    import packet_distributor_pkg::*;
#(
    parameter int DATA_WIDTH   = 12'h0FF,
    parameter int LENGTH_WIDTH = 8'h1F
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_WIDTH:0] DATA_IN,
    input  logic                valid_in,
    output logic                ready,
    output logic [DATA_WIDTH:0] DATA_OUT1,
    output logic                valid_1,
    input  logic                ready_1,
    output logic [DATA_WIDTH:0] DATA_OUT2,
    output logic                valid_2,
    input  logic                ready_2,
    output logic                busy
`ifdef DISTRIB_PKT_CNT_EN
    ,
    output logic [15:0]         pkt_cnt_1,
    output logic [15:0]         pkt_cnt_2
`endif
);

    localparam int CW = LENGTH_WIDTH + 1;

    state_e          state_q, state_d;
    engine_e         next_engine_q, next_engine_d;
    logic [CW-1:0]   rows_left_q, rows_left_d;
    logic [CW-1:0]   rows;
    logic            load_rdy_1, load_rdy_2;
    logic            accept;
    logic            last_beat;

    // Engine selection is latched per packet, so a packet never straddles both engines.
    assign ready  = (next_engine_q == ENGINE1) ? load_rdy_1 : load_rdy_2;
    assign accept = valid_in && ready;
    assign busy   = (state_q == BODY);

    engine_out_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage_1 (
        .clk      (clk),
        .reset    (reset),
        .load_vld (accept && (next_engine_q == ENGINE1)),
        .load_dat (DATA_IN),
        .load_rdy (load_rdy_1),
        .out_dat  (DATA_OUT1),
        .out_vld  (valid_1),
        .out_rdy  (ready_1)
    );

    engine_out_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage_2 (
        .clk      (clk),
        .reset    (reset),
        .load_vld (accept && (next_engine_q == ENGINE2)),
        .load_dat (DATA_IN),
        .load_rdy (load_rdy_2),
        .out_dat  (DATA_OUT2),
        .out_vld  (valid_2),
        .out_rdy  (ready_2)
    );

    always_comb begin
        state_d       = state_q;
        next_engine_d = next_engine_q;
        rows_left_d   = rows_left_q;
        last_beat     = 1'b0;
        // Body beats still to come after this header; all-ones LENGTH still fits in CW bits.
        rows          = DATA_IN[LENGTH_WIDTH:0] >> ROW_SHIFT;
        if (accept) begin
            case (state_q)
                HEADER: begin
                    if (rows == '0) begin
                        last_beat     = 1'b1;
                        next_engine_d = other_engine(next_engine_q);
                    end else begin
                        rows_left_d = rows;
                        state_d     = BODY;
                    end
                end
                BODY: begin
                    rows_left_d = rows_left_q - CW'(1);
                    if (rows_left_q == CW'(1)) begin
                        last_beat     = 1'b1;
                        state_d       = HEADER;
                        next_engine_d = other_engine(next_engine_q);
                    end
                end
                default: state_d = HEADER;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HEADER;
            next_engine_q <= ENGINE1;
            rows_left_q   <= '0;
        end else begin
            state_q       <= state_d;
            next_engine_q <= next_engine_d;
            rows_left_q   <= rows_left_d;
        end
    end

`ifdef DISTRIB_PKT_CNT_EN
    logic [15:0] pkt_cnt_1_q, pkt_cnt_1_d;
    logic [15:0] pkt_cnt_2_q, pkt_cnt_2_d;

    assign pkt_cnt_1 = pkt_cnt_1_q;
    assign pkt_cnt_2 = pkt_cnt_2_q;

    // Counted when the final beat enters the stage; wraps naturally at 16 bits.
    always_comb begin
        pkt_cnt_1_d = pkt_cnt_1_q;
        pkt_cnt_2_d = pkt_cnt_2_q;
        if (last_beat && (next_engine_q == ENGINE1)) pkt_cnt_1_d = pkt_cnt_1_q + 16'd1;
        if (last_beat && (next_engine_q == ENGINE2)) pkt_cnt_2_d = pkt_cnt_2_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_1_q <= '0;
            pkt_cnt_2_q <= '0;
        end else begin
            pkt_cnt_1_q <= pkt_cnt_1_d;
            pkt_cnt_2_q <= pkt_cnt_2_d;
        end
    end
`endif

endmodule
